// File: rtl/branch_predictor_if.sv
// Fetch-lookup, branch-resolution and statistics signals of the branch predictor.
// The master drives fetch and update requests; the slave (the predictor) answers.
interface branch_predictor_if #(
    parameter int PC_W   = 8,
    parameter int STAT_W = 16
);
    logic [PC_W-1:0]   fetch_pc;
    logic              pred_hit;
    logic              pred_taken;
    logic [PC_W-1:0]   pred_next_pc;
    logic              upd_valid;
    logic [PC_W-1:0]   upd_pc;
    logic              upd_taken;
    logic [PC_W-1:0]   upd_target;
    logic              flush;
    logic              upd_mispredict;
    logic [STAT_W-1:0] branch_cnt;
    logic [STAT_W-1:0] miss_cnt;

    modport master (
        output fetch_pc, upd_valid, upd_pc, upd_taken, upd_target, flush,
        input  pred_hit, pred_taken, pred_next_pc, upd_mispredict, branch_cnt, miss_cnt
    );

    modport slave (
        input  fetch_pc, upd_valid, upd_pc, upd_taken, upd_target, flush,
        output pred_hit, pred_taken, pred_next_pc, upd_mispredict, branch_cnt, miss_cnt
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters
// and saturating branch/mispredict statistics.
module branch_predictor #(
    parameter int PC_W    = 8,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int STAT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    branch_predictor_if.slave  bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [PC_W-1:0]  r_target [ENTRIES];
    logic [CTR_W-1:0] r_ctr    [ENTRIES];

    logic [STAT_W-1:0] r_branch_cnt;
    logic [STAT_W-1:0] r_miss_cnt;

    logic [IDX_W-1:0] w_f_idx;
    logic [TAG_W-1:0] w_f_tag;
    logic             w_f_hit;
    logic             w_f_taken;

    logic [IDX_W-1:0] w_u_idx;
    logic [TAG_W-1:0] w_u_tag;
    logic             w_u_hit;
    logic             w_u_pred_taken;
    logic             w_mispredict;

    logic             w_unused_lsbs;

    assign w_unused_lsbs = ^{bus.fetch_pc[1:0], bus.upd_pc[1:0]};

    // Fetch-side lookup
    assign w_f_idx   = bus.fetch_pc[IDX_W+1:2];
    assign w_f_tag   = bus.fetch_pc[PC_W-1:IDX_W+2];
    assign w_f_hit   = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    assign w_f_taken = w_f_hit && r_ctr[w_f_idx][CTR_W-1];

    assign bus.pred_hit     = w_f_hit;
    assign bus.pred_taken   = w_f_taken;
    assign bus.pred_next_pc = w_f_taken ? r_target[w_f_idx] : bus.fetch_pc + PC_W'(4);

    // Update-side lookup against the pre-edge table contents
    assign w_u_idx        = bus.upd_pc[IDX_W+1:2];
    assign w_u_tag        = bus.upd_pc[PC_W-1:IDX_W+2];
    assign w_u_hit        = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
    assign w_u_pred_taken = w_u_hit && r_ctr[w_u_idx][CTR_W-1];

    assign w_mispredict = bus.upd_valid &&
                          ((w_u_pred_taken != bus.upd_taken) ||
                           (bus.upd_taken && w_u_pred_taken &&
                            (r_target[w_u_idx] != bus.upd_target)));

    assign bus.upd_mispredict = w_mispredict;
    assign bus.branch_cnt     = r_branch_cnt;
    assign bus.miss_cnt       = r_miss_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= CTR_WNT;
            end
        end else if (bus.flush) begin
            // Flush beats a simultaneous update: only valid bits change
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
            end
        end else if (bus.upd_valid) begin
            if (w_u_hit) begin
                if (bus.upd_taken) begin
                    r_target[w_u_idx] <= bus.upd_target;
                    if (r_ctr[w_u_idx] != '1) begin
                        r_ctr[w_u_idx] <= r_ctr[w_u_idx] + CTR_W'(1);
                    end
                end else if (r_ctr[w_u_idx] != '0) begin
                    r_ctr[w_u_idx] <= r_ctr[w_u_idx] - CTR_W'(1);
                end
            end else begin
                r_valid[w_u_idx]  <= 1'b1;
                r_tag[w_u_idx]    <= w_u_tag;
                r_target[w_u_idx] <= bus.upd_target;
                r_ctr[w_u_idx]    <= bus.upd_taken ? CTR_WT : CTR_WNT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_branch_cnt <= '0;
            r_miss_cnt   <= '0;
        end else begin
            if (bus.upd_valid && (r_branch_cnt != '1)) begin
                r_branch_cnt <= r_branch_cnt + STAT_W'(1);
            end
            if (w_mispredict && (r_miss_cnt != '1)) begin
                r_miss_cnt <= r_miss_cnt + STAT_W'(1);
            end
        end
    end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter PC_W, default 8: program-counter width in bits.
REQ-002 SHALL have parameter ENTRIES, default 16: table depth; power of two, ≥2; IDX_W = log2(ENTRIES).
REQ-003 SHALL have parameter CTR_W, default 2: saturating-counter width, ≥1; constraint PC_W ≥ IDX_W+3.
REQ-004 SHALL have parameter STAT_W, default 16: statistics counter width.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 fetch_pc  input  PC_W  PC being fetched, lookup address.
REQ-008 pred_hit  output  1  valid entry with matching tag at fetch_pc.
REQ-009 pred_taken  output  1  predicted taken.
REQ-010 pred_next_pc  output  PC_W  predicted next fetch PC.
REQ-011 upd_valid  input  1  resolved-branch update strobe, one cycle per branch.
REQ-012 upd_pc  input  PC_W  PC of the resolved branch.
REQ-013 upd_taken  input  1  actual outcome.
REQ-014 upd_target  input  PC_W  actual taken target.
REQ-015 flush  input  1  synchronous invalidate-all.
REQ-016 upd_mispredict  output  1  combinational: current update disagrees with table prediction.
REQ-017 branch_cnt  output  STAT_W  count of accepted updates.
REQ-018 miss_cnt  output  STAT_W  count of mispredicted updates.

Function
REQ-019 Index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]; pc[1:0] SHALL be ignored.
REQ-020 Each entry SHALL hold valid, tag, target (PC_W), counter (CTR_W).
REQ-021 Lookup SHALL be combinational: pred_hit = valid && tag match; pred_taken = pred_hit && counter MSB.
REQ-022 pred_next_pc SHALL be stored target if pred_taken, else fetch_pc+4 modulo 2^PC_W (wraps 0xFC→0x00 at PC_W=8).
REQ-023 Update entry lookup SHALL use the same rule on upd_pc, using pre-edge table state.
REQ-024 upd_mispredict = upd_valid && (predicted_taken != upd_taken || (upd_taken && predicted_taken && target != upd_target)); 0 when upd_valid=0.
REQ-025 On upd_valid with hit: counter +1 if taken, −1 if not, saturating at 2^CTR_W−1 and 0; target overwritten with upd_target when taken.
REQ-026 On upd_valid with miss: allocate/replace entry: valid=1, tag written, target=upd_target, counter = taken ? weakly-taken (MSB=1, rest 0) : weakly-not-taken (MSB=0, rest 1).
REQ-027 Table changes SHALL be visible to lookup on the cycle after the update edge; no same-cycle bypass.
REQ-028 branch_cnt SHALL increment on each upd_valid; miss_cnt SHALL increment when upd_mispredict; both saturate at 2^STAT_W−1.
REQ-029 flush SHALL clear all valid bits at the edge; counters, targets, stats unchanged.
REQ-030 flush and upd_valid in the same cycle: flush wins; update discarded for the table, but stats still count it.

Reset
REQ-031 rst SHALL asynchronously clear all valid bits, set all counters to weakly-not-taken, targets and tags to 0, branch_cnt and miss_cnt to 0.
REQ-032 During/after reset, outputs: pred_hit=0, pred_taken=0, pred_next_pc=fetch_pc+4, upd_mispredict per inputs (0 if upd_valid=0).
REQ-033 rst asserted mid-update SHALL discard that update; no partial entry write.

Verification (PC_W=8, ENTRIES=16, CTR_W=2)
REQ-034 Post-reset lookup fetch_pc=0x10 -> pred_hit=0, pred_taken=0, pred_next_pc=0x14; fetch_pc=0xFC -> pred_next_pc=0x00.
REQ-035 Update pc=0x10 taken target 0x40 -> upd_mispredict=1; next cycle lookup 0x10: hit=1, taken=1, next_pc=0x40; branch_cnt=1, miss_cnt=1.
REQ-036 Then two not-taken updates at 0x10 -> counter 2→1→0; first update mispredicts, second does not; lookup 0x10 taken=0, next_pc=0x14.
REQ-037 Three taken updates at 0x20 -> counter saturates at 3; one not-taken -> counter 2, still predicts taken with target retained.
REQ-038 Aliasing: entry at 0x10 valid; update 0x50 (same index 4, tag 1) -> lookup 0x10 hit=0, lookup 0x50 hit=1.
REQ-039 flush with simultaneous upd_valid at 0x30 -> all lookups miss next cycle, branch_cnt incremented; rst asserted mid-sequence clears stats to 0 immediately, without waiting for clk.
